// File: rtl/serv_rf_ram_resp.sv
// serv_rf_ram_resp: RAM-side responder owning the SERV SRAM register-file storage.
// Latency: read data is registered, visible one clock after i_ren; writes land at the clock edge.
// Backpressure: none; a read and a write are both accepted every RUN cycle, and o_init_done gates use during the sweep.
//
// After every reset the block sweeps all used words to zero, one word per cycle
// (INIT), then enters RUN and raises o_init_done. RUN is left only by reset.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset
//   i_waddr      write word address (aw bits)
//   i_wdata      write data (width bits)
//   i_wen        write strobe (ignored during INIT and for addresses >= depth)
//   i_raddr      read word address (aw bits)
//   i_ren        read strobe; o_rdata holds when low
//   o_rdata      registered read data
//   o_init_done  high once the zero-fill sweep has completed
//
// Build option: define SERV_RF_RAM_BYPASS_EN to return i_wdata on a same-cycle
// read and write to the same in-range, non-x0 word. Without it the read sees
// the old memory word (read-before-write).

module serv_rf_ram_resp #(
  parameter int width    = 8,
  parameter int csr_regs = 4,
  parameter int raw      = $clog2(32 + csr_regs),
  parameter int l2w      = $clog2(width),
  parameter int aw       = 5 + raw - l2w,
  parameter int depth    = (32 + csr_regs) * 32 / width
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [aw-1:0]    i_waddr,
  input  logic [width-1:0] i_wdata,
  input  logic             i_wen,
  input  logic [aw-1:0]    i_raddr,
  input  logic             i_ren,
  output logic [width-1:0] o_rdata,
  output logic             o_init_done
);

  // Depth as an aw+1 bit constant so range checks compare equal widths.
  localparam logic [aw:0]   depth_c = (aw + 1)'(depth);
  localparam logic [aw-1:0] last_c  = aw'(depth - 1);
  localparam logic [aw-1:0] one_c   = aw'(1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [aw-1:0]    icnt_q, icnt_d;
  logic [width-1:0] rdata_q, rdata_d;

  logic [width-1:0] mem_q [depth];

  logic             mem_we;
  logic [aw-1:0]    mem_waddr;
  logic [width-1:0] mem_wdata;

  logic             waddr_in_range;
  logic             raddr_in_range;
  logic             raddr_is_x0;

  assign waddr_in_range = {1'b0, i_waddr} < depth_c;
  assign raddr_in_range = {1'b0, i_raddr} < depth_c;
  // The first 32/width words make up register x0.
  assign raddr_is_x0    = (i_raddr[aw-1:5-l2w] == '0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_INIT;
      icnt_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      icnt_q  <= icnt_d;
      rdata_q <= rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: sweep one word per cycle, leave INIT after the last one.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    icnt_d  = icnt_q;
    case (state_q)
      ST_INIT: begin
        icnt_d = icnt_q + one_c;
        if (icnt_q == last_c) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / write-port logic
  // ---------------------------------------------------------------------------
  always_comb begin
    o_init_done = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = i_waddr;
    mem_wdata   = i_wdata;
    case (state_q)
      ST_INIT: begin
        // The sweep owns the write port; external writes are dropped.
        mem_we    = 1'b1;
        mem_waddr = icnt_q;
        mem_wdata = '0;
      end
      ST_RUN: begin
        o_init_done = 1'b1;
        mem_we      = i_wen && waddr_in_range;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
    // No storage update on a reset cycle; the following sweep clears it anyway.
    if (i_rst) begin
      mem_we = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read data: x0 words and out-of-range addresses read as zero, reads during
  // INIT return zero, otherwise the stored word (or the bypassed write data).
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_d = rdata_q;
    if (i_ren) begin
      if (state_q != ST_RUN) begin
        rdata_d = '0;
      end else if (raddr_is_x0 || !raddr_in_range) begin
        rdata_d = '0;
      end else begin
        rdata_d = mem_q[i_raddr];
`ifdef SERV_RF_RAM_BYPASS_EN
        if (i_wen && (i_waddr == i_raddr)) begin
          rdata_d = i_wdata;
        end
`endif
      end
    end
  end

  assign o_rdata = rdata_q;

  // ---------------------------------------------------------------------------
  // Storage: plain synchronous write port, no reset on the array itself.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule
